// File: rtl/des_stream_top.sv
// des_stream_top: fully pipelined DES encrypt/decrypt engine.
// A sequential key schedule fills a 16-entry subkey store, one entry per
// cycle. A 17-register Feistel pipeline then accepts one block per clock.
// Bit numbering follows FIPS 46-3: FIPS bit 1 is vector bit [63].
module des_stream_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        encrypt,
  input  logic [63:0] keys_64_in,
  input  logic        change_keys_en,
  output logic        subkeys_16_valid,
  input  logic        data_input_en,
  input  logic [63:0] data_64_in,
  output logic [63:0] data_64_out
);

  // Permutation tables, 1-based FIPS bit numbers of the source vector.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // S-boxes, flattened: entry index is {row(2), column(4)}.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
    return o;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] k);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_T[i]];
    return o;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] cd);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
    return o;
  endfunction

  // Round function f(R, K): expand, key mix, S-box substitution, P.
  function automatic logic [31:0] feistel_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [47:0] x;
    logic [5:0]  six;
    logic [31:0] s;
    logic [31:0] o;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    x = e ^ k;
    for (int i = 0; i < 8; i++) begin
      six = x[47-6*i -: 6];
      s[31-4*i -: 4] = 4'(SBOX[i][{six[5], six[0], six[4:1]}]);
    end
    for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
    return o;
  endfunction

  // Key schedule state
  logic [27:0] c_half_q, c_half_d, d_half_q, d_half_d;
  logic [27:0] c_rot, d_rot;
  logic        one_shift;
  logic [3:0]  slot;
  logic [4:0]  round_q, round_d;
  logic        gen_busy_q, gen_busy_d;
  logic        keys_valid_q, keys_valid_d;
  logic        encrypt_q, encrypt_d;
  logic [47:0] subkey_q [16];
  logic [47:0] subkey_d [16];

  // Pipeline state: stage 0 holds IP(block), stage s holds L_s/R_s
  logic [31:0] l_q [17];
  logic [31:0] l_d [17];
  logic [31:0] r_q [17];
  logic [31:0] r_d [17];
  logic [16:0] v_q, v_d;
  logic        accept;
  logic [63:0] data_out_q, data_out_d;

  // Key schedule: load C/D on request, then derive one subkey per cycle.
  always_comb begin
    // NOTE: every _d starts from its _q value, so no path through this block leaves a signal unassigned and no latch is inferred.
    c_half_d     = c_half_q;
    d_half_d     = d_half_q;
    round_d      = round_q;
    gen_busy_d   = gen_busy_q;
    keys_valid_d = keys_valid_q;
    encrypt_d    = encrypt_q;
    subkey_d     = subkey_q;
    one_shift    = (round_q == 5'd0) || (round_q == 5'd1) || (round_q == 5'd8) || (round_q == 5'd15);
    c_rot        = one_shift ? {c_half_q[26:0], c_half_q[27]} : {c_half_q[25:0], c_half_q[27:26]};
    d_rot        = one_shift ? {d_half_q[26:0], d_half_q[27]} : {d_half_q[25:0], d_half_q[27:26]};
    // Decrypt stores subkeys reversed so stage s always reads slot s-1.
    slot         = encrypt_q ? round_q[3:0] : ~round_q[3:0];
    if (change_keys_en) begin
      {c_half_d, d_half_d} = pc1_f(keys_64_in);
      round_d      = '0;
      gen_busy_d   = 1'b1;
      keys_valid_d = 1'b0;
      encrypt_d    = encrypt;
    end else if (gen_busy_q) begin
      if (round_q == 5'd16) begin
        keys_valid_d = 1'b1;
        gen_busy_d   = 1'b0;
      end else begin
        c_half_d       = c_rot;
        d_half_d       = d_rot;
        subkey_d[slot] = pc2_f({c_rot, d_rot});
        round_d        = round_q + 5'd1;
      end
    end
  end

  // Datapath: IP capture, sixteen Feistel stages, final swap + FP.
  always_comb begin
    l_d        = l_q;
    r_d        = r_q;
    v_d        = '0;
    data_out_d = data_out_q;
    // A key load discards the incoming block and every token in flight.
    accept     = data_input_en & keys_valid_q & ~change_keys_en;
    v_d[0]     = accept;
    if (accept) {l_d[0], r_d[0]} = ip_f(data_64_in);
    for (int s = 1; s < 17; s++) begin
      l_d[s] = r_q[s-1];
      r_d[s] = l_q[s-1] ^ feistel_f(r_q[s-1], subkey_q[s-1]);
      v_d[s] = v_q[s-1] & ~change_keys_en;
    end
    if (v_q[16] && !change_keys_en) data_out_d = fp_f({r_q[16], l_q[16]});
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_half_q     <= '0;
      d_half_q     <= '0;
      round_q      <= '0;
      gen_busy_q   <= 1'b0;
      keys_valid_q <= 1'b0;
      encrypt_q    <= 1'b0;
      // NOTE: the subkey store is reset like ordinary flops rather than left as RAM, so nothing from an old key survives a reset.
      subkey_q     <= '{default: '0};
      l_q          <= '{default: '0};
      r_q          <= '{default: '0};
      v_q          <= '0;
      data_out_q   <= '0;
    end else begin
      // NOTE: <= makes every flop sample pre-edge values; = would let a block race through several stages in one edge.
      c_half_q     <= c_half_d;
      d_half_q     <= d_half_d;
      round_q      <= round_d;
      gen_busy_q   <= gen_busy_d;
      keys_valid_q <= keys_valid_d;
      encrypt_q    <= encrypt_d;
      subkey_q     <= subkey_d;
      l_q          <= l_d;
      r_q          <= r_d;
      v_q          <= v_d;
      data_out_q   <= data_out_d;
    end
  end

  assign subkeys_16_valid = keys_valid_q;
  assign data_64_out      = data_out_q;

endmodule

// File: tb/tb_des_stream_top.sv
// tb_des_stream_top: scoreboard bench for des_stream_top. The stimulus thread
// models key-load/valid timing and pushes each accepted block's DES result
// (from a plain software DES model) with its due edge; a monitor thread
// compares data_64_out and subkeys_16_valid every falling edge.
module tb_des_stream_top;

  logic        clk;
  logic        rst;
  logic        encrypt;
  logic [63:0] keys_64_in;
  logic        change_keys_en;
  logic        subkeys_16_valid;
  logic        data_input_en;
  logic [63:0] data_64_in;
  logic [63:0] data_64_out;

  des_stream_top dut (
    .clk              (clk),
    .rst              (rst),
    .encrypt          (encrypt),
    .keys_64_in       (keys_64_in),
    .change_keys_en   (change_keys_en),
    .subkeys_16_valid (subkeys_16_valid),
    .data_input_en    (data_input_en),
    .data_64_in       (data_64_in),
    .data_64_out      (data_64_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIPS 46-3 tables, padded with zeros to a common length of 64.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
    64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5,
    63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
    37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26,
    33,1,41,9,49,17,57,25};
  localparam int E_T [64] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1,
    0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
  localparam int P_T [64] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9,
    19,13,30,6,22,11,4,25, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
  localparam int PC1_T [64] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29,
    21,13,5,28,20,12,4, 0,0,0,0,0,0,0,0};
  localparam int PC2_T [64] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32,
    0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
  localparam int SB [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT_B  = 64'h8787878787878787;

  // Generic FIPS permutation: output bit i (1-based) = input bit tab[i-1].
  function automatic logic [63:0] permute(input logic [63:0] x, input int in_w, input int out_w,
                                          input int tab [64]);
    logic [63:0] o;
    o = '0;
    for (int i = 1; i <= out_w; i++) o[out_w-i] = x[in_w-tab[i-1]];
    return o;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] v, input int n);
    return (v << n) | (v >> (28 - n));
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] t, input logic [47:0] k);
    logic [63:0] e;
    logic [63:0] p;
    logic [47:0] x;
    logic [31:0] s;
    int six, row, col;
    e = permute({32'h0, t}, 32, 48, E_T);
    x = e[47:0] ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      six = int'((x >> (42 - 6*j)) & 48'h3F);
      row = ((six >> 4) & 2) | (six & 1);
      col = (six >> 1) & 15;
      s   = (s << 4) | 32'(SB[j][row][col]);
    end
    p = permute({32'h0, s}, 32, 32, P_T);
    return p[31:0];
  endfunction

  // Whole-block DES, key schedule recomputed per call.
  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input logic enc);
    logic [47:0] ks [1:16];
    logic [63:0] cd, x;
    logic [27:0] c, d;
    logic [31:0] l, r, t;
    int sh;
    cd = permute(key, 64, 56, PC1_T);
    c  = cd[55:28];
    d  = cd[27:0];
    for (int n = 1; n <= 16; n++) begin
      sh = (n == 1 || n == 2 || n == 9 || n == 16) ? 1 : 2;
      c  = rotl28(c, sh);
      d  = rotl28(d, sh);
      cd = permute({8'h00, c, d}, 56, 48, PC2_T);
      ks[n] = cd[47:0];
    end
    x = permute(blk, 64, 64, IP_T);
    l = x[63:32];
    r = x[31:0];
    for (int n = 1; n <= 16; n++) begin
      t = r;
      r = l ^ f_ref(t, enc ? ks[n] : ks[17-n]);
      l = t;
    end
    return permute({r, l}, 64, 64, FP_T);
  endfunction

  typedef struct {
    int unsigned due;
    logic [63:0] val;
  } exp_t;

  exp_t        sb [$];
  int unsigned edge_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        loaded = 1'b0;
  int          since = 0;
  logic [63:0] cur_key = '0;
  logic        cur_enc = 1'b0;
  logic        exp_kv = 1'b0;
  logic [63:0] exp_out = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock: drive inputs, take the edge, then advance the model.
  task automatic tick(input logic cke, input logic enc, input logic [63:0] key,
                      input logic den, input logic [63:0] din);
    exp_t e;
    change_keys_en = cke;
    encrypt        = enc;
    keys_64_in     = key;
    data_input_en  = den;
    data_64_in     = din;
    @(posedge clk);
    edge_cnt++;
    if (cke) begin
      sb.delete();
      loaded  = 1'b1;
      since   = 0;
      cur_key = key;
      cur_enc = enc;
    end else begin
      if (den && loaded && since >= 17) begin
        e.due = edge_cnt + 17;
        e.val = des_ref(cur_key, din, cur_enc);
        sb.push_back(e);
      end
      if (loaded && since < 17) since++;
    end
    exp_kv = loaded && (since >= 17);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Monitor: the registered output either takes the due result or holds.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_out = '0;
      end else if (sb.size() > 0 && sb[0].due == edge_cnt) begin
        e       = sb.pop_front();
        exp_out = e.val;
      end
      check("mon_data_out", data_64_out, exp_out);
      check("mon_keys_valid", 64'(subkeys_16_valid), 64'(exp_kv));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] kr;
    logic        m;
    rst = 1'b1; encrypt = 1'b0; keys_64_in = '0; change_keys_en = 1'b0;
    data_input_en = 1'b0; data_64_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_data_out", data_64_out, '0);
    check("reset_keys_valid", 64'(subkeys_16_valid), '0);

    // Strobes with no key loaded are ignored.
    repeat (4) tick(1'b0, 1'b0, '0, 1'b1, rnd64());

    // Two-cycle key pulse; strobes during generation are ignored.
    tick(1'b1, 1'b1, KEY_A, 1'b0, '0);
    tick(1'b1, 1'b1, KEY_A, 1'b0, '0);
    repeat (16) tick(1'b0, 1'b0, '0, 1'b1, rnd64());
    check("keys_valid_edge16", 64'(subkeys_16_valid), '0);
    idle(1);
    check("keys_valid_edge17", 64'(subkeys_16_valid), 64'd1);
    check("gate_hold", data_64_out, '0);
    check("subkey_k1", {16'h0, dut.subkey_q[0]}, 64'h1B02EFFC7072);
    check("subkey_k16", {16'h0, dut.subkey_q[15]}, 64'hCB3D8B0E17F5);

    // Known-answer encrypt, 17-edge latency.
    tick(1'b0, 1'b0, '0, 1'b1, PT_A);
    idle(16);
    check("latency_16", data_64_out, '0);
    idle(1);
    check("kat_encrypt", data_64_out, CT_A);
    idle(3);

    // Decrypt load with a simultaneous strobe (dropped), then known answer.
    tick(1'b1, 1'b0, KEY_A, 1'b1, PT_A);
    idle(17);
    tick(1'b0, 1'b0, '0, 1'b1, CT_A);
    idle(17);
    check("kat_decrypt", data_64_out, PT_A);

    tick(1'b1, 1'b1, KEY_B, 1'b0, '0);
    idle(17);
    tick(1'b0, 1'b0, '0, 1'b1, PT_B);
    idle(17);
    check("kat_key_b", data_64_out, '0);

    // Back-to-back stream of 20 alternating blocks.
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, '0, 1'b1, (i % 2 == 1) ? PT_B : PT_A);
    idle(18);
    check("stream_last", data_64_out, '0);

    // Reload while blocks are in flight: none of them may come out.
    repeat (5) tick(1'b0, 1'b0, '0, 1'b1, PT_A);
    tick(1'b1, 1'b1, KEY_A, 1'b0, '0);
    idle(25);
    check("discard_hold", data_64_out, '0);

    // Randomized keys, modes, strobes and mid-stream reloads.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        kr = rnd64();
        m  = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 2)) tick(1'b1, m, kr, 1'($urandom_range(0, 1)), rnd64());
      end else begin
        tick(1'b0, 1'b0, '0, $urandom_range(0, 99) < 70, rnd64());
      end
    end

    // Asynchronous reset between edges while results are streaming.
    tick(1'b1, 1'b1, rnd64(), 1'b0, '0);
    idle(17);
    repeat (25) tick(1'b0, 1'b0, '0, 1'b1, rnd64());
    #2 rst = 1'b1;
    sb.delete();
    loaded = 1'b0;
    since  = 0;
    exp_kv = 1'b0;
    #1;
    check("async_data_out", data_64_out, '0);
    check("async_keys_valid", 64'(subkeys_16_valid), '0);
    @(posedge clk);
    #1 rst = 1'b0;

    // After reset nothing is accepted until a fresh key load.
    repeat (3) tick(1'b0, 1'b0, '0, 1'b1, rnd64());
    tick(1'b1, 1'b0, rnd64(), 1'b0, '0);
    idle(17);
    repeat (60) tick(1'b0, 1'b0, '0, $urandom_range(0, 99) < 80, rnd64());
    idle(20);
    check("scoreboard_drained", 64'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/des_stream_top.md
Name: des_stream_top

Overview:
- Fully pipelined DES (FIPS 46-3) encrypt/decrypt engine with an on-chip sequential key schedule.
- A 64-bit key is loaded once. All 16 subkeys are generated one per cycle and stored. Afterwards the datapath accepts one 64-bit block per clock and streams results out after a fixed latency.
- Sits between a host key/config interface and a streaming data source/sink.

Parameters:
- none (algorithm fixed; all widths fixed at 64-bit block, 48-bit subkey).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- encrypt  in  1  mode, sampled with the key: 1 = encrypt, 0 = decrypt.
- keys_64_in  in  64  DES key, bit [1] = MSB (FIPS numbering); parity bits ignored.
- change_keys_en  in  1  key load request (level, sampled each edge).
- subkeys_16_valid  out  1  high when all 16 subkeys are ready for the latched key/mode.
- data_input_en  in  1  input block strobe, one block per edge while high.
- data_64_in  in  64  plaintext (encrypt) or ciphertext (decrypt), bit [1] = MSB.
- data_64_out  out  64  result block, registered.

Behaviour:
- Reset (async, rst=1):
  - subkeys_16_valid=0, data_64_out=0.
  - All subkey storage, the key-schedule counter, pipeline data and pipeline valid bits are cleared.
- Key load:
  - On each edge with change_keys_en=1: latch keys_64_in and encrypt, apply PC-1 into C/D registers, reset the round counter to 0.
  - subkeys_16_valid goes to 0 at the same edge.
  - Holding change_keys_en high for several cycles restarts the load every edge; the last sampled key wins.
- Key generation:
  - On each following edge with change_keys_en=0, compute one subkey: rotate C/D left 1 bit (rounds 1, 2, 9, 16) or 2 bits (others), apply PC-2, store as K[round].
  - Encrypt: rounds use K1..K16 in order. Decrypt: rounds use K16..K1 (reversed at store or read time).
  - subkeys_16_valid=1 on the edge after K16 is stored, i.e. the 17th edge after the last edge with change_keys_en=1. It stays 1 until the next key load or reset.
- Datapath:
  - Stage 0 register captures IP(data_64_in) on an edge where data_input_en=1 and subkeys_16_valid=1.
  - data_input_en while subkeys_16_valid=0 is ignored; no token is inserted.
  - Stages 1..16 each perform one Feistel round: E-expand, XOR subkey, S1..S8, P, XOR L, swap.
  - The final stage applies the 32-bit half swap (R16L16) and FP, and registers the result into data_64_out.
  - Each stage carries a valid bit. The pipeline advances every clock, with no stall or backpressure.
- Latency and output:
  - A block sampled at edge N appears on data_64_out after edge N+17.
  - Throughput is 1 block/clock.
  - data_64_out updates only when a valid token exits; otherwise it holds its last value.
  - Consecutive blocks appear on consecutive cycles.
- Key change while blocks are in flight: all pipeline valid bits are cleared at the load edge. In-flight blocks are discarded and data_64_out holds.
- Simultaneous change_keys_en=1 and data_input_en=1: the key load wins and the block is dropped.
- Reset mid-operation: takes effect immediately. After release, a fresh key load is needed.

Test Plan:
- Key load and timing: reset, pulse change_keys_en for 2 clocks with key 0x133457799BBCDFF1, encrypt=1 -> subkeys_16_valid rises exactly 17 edges after the last enable edge. K1 = 0x1B02EFFC7072, K16 = 0xCB3D8B0E17F5.
- Encrypt: with that key, feed 0x0123456789ABCDEF for one cycle -> data_64_out = 0x85E813540F0AB405 after 17 edges.
- Decrypt: same key, encrypt=0, feed 0x85E813540F0AB405 -> 0x0123456789ABCDEF. Also key 0x0E329232EA6D0D73 encrypt 0x8787878787878787 -> 0x0000000000000000.
- Streaming: hold data_input_en for 20 cycles with alternating inputs 0x0123456789ABCDEF / 0x8787878787878787 under key 0x0E329232EA6D0D73 -> 20 back-to-back correct outputs, no gaps.
- Gating and discard:
  - data_input_en asserted before subkeys_16_valid -> data_64_out remains 0.
  - Key reload while blocks are in flight -> those outputs are never produced and data_64_out holds.
- Async reset: assert rst mid-stream between clock edges -> subkeys_16_valid and data_64_out go to 0 immediately, without waiting for a clock edge.
